// File: rtl/output_layer_pkg.sv
// Shared types and default parameters for the output-layer classifier.
// Holds the FSM encoding plus the default weight/bias tables.
package output_layer_pkg;

  localparam int N_OUT_DEF = 4;
  localparam int ACC_W_DEF = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_CMP,
    S_DONE
  } state_t;

  // Row k favours hidden bits 2k and 2k+1.
  localparam logic signed [7:0] W_DEF [4][8] = '{
    '{8'sd16, 8'sd16, -8'sd4, -8'sd4,
      -8'sd4, -8'sd4, -8'sd4, -8'sd4},
    '{-8'sd4, -8'sd4, 8'sd16, 8'sd16,
      -8'sd4, -8'sd4, -8'sd4, -8'sd4},
    '{-8'sd4, -8'sd4, -8'sd4, -8'sd4,
      8'sd16, 8'sd16, -8'sd4, -8'sd4},
    '{-8'sd4, -8'sd4, -8'sd4, -8'sd4,
      -8'sd4, -8'sd4, 8'sd16, 8'sd16}
  };

  localparam logic signed [7:0] B_DEF [4] = '{
    8'sd0, 8'sd0, 8'sd0, 8'sd0
  };

endpackage

// File: rtl/output_mac.sv
// Accumulate/compare datapath: one weight add per cycle,
// running argmax over neuron scores.
module output_mac #(
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_i,
  input  logic                    add_i,
  input  logic                    cmp_i,
  input  logic                    first_i,
  input  logic                    bit_i,
  input  logic [1:0]              idx_i,
  input  logic signed [7:0]       bias_i,
  input  logic signed [7:0]       term_i,
  output logic signed [ACC_W-1:0] best_score_o,
  output logic [1:0]              best_idx_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic [1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0] bias_x, term_x;

  assign bias_x = {{(ACC_W-8){bias_i[7]}}, bias_i};
  assign term_x = {{(ACC_W-8){term_i[7]}}, term_i};

  always_comb begin
    acc_d  = acc_q;
    best_d = best_q;
    idx_d  = idx_q;
    if (init_i)
      acc_d = bias_x;
    else if (add_i && bit_i)
      acc_d = acc_q + term_x;
    // Strict compare keeps the lowest index on ties.
    if (cmp_i && (first_i || acc_q > best_q)) begin
      best_d = acc_q;
      idx_d  = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign best_score_o = best_q;
  assign best_idx_o   = idx_q;

endmodule

// File: rtl/tt_um_output_layer.sv
// Output layer: scores N_OUT neurons serially and reports the argmax.
// Define OUTPUT_LAYER_WEIGHT_LOAD_EN for run-time loadable weights.
module tt_um_output_layer
  import output_layer_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              hid_in,
  input  logic                    hid_valid,
  output logic                    hid_ready,
  output logic [1:0]              cls_out,
  output logic signed [ACC_W-1:0] score_out,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef OUTPUT_LAYER_WEIGHT_LOAD_EN
  ,
  input  logic                    wl_en,
  input  logic [5:0]              wl_addr,
  input  logic signed [7:0]       wl_data
`endif
);

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  hid_q, hid_d;
  logic        init, add, cmp;
  logic signed [7:0] bias_sel, term_sel;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bit_d   = bit_q;
    hid_d   = hid_q;
    init    = 1'b0;
    add     = 1'b0;
    cmp     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hid_valid) begin
          hid_d   = hid_in;
          k_d     = 2'd0;
          bit_d   = 3'd0;
          init    = 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        add   = 1'b1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7)
          state_d = S_CMP;
      end
      S_CMP: begin
        cmp = 1'b1;
        if (k_q == 2'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 2'd1;
          init    = 1'b1;
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      bit_q   <= '0;
      hid_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      hid_q   <= hid_d;
    end
  end

`ifdef OUTPUT_LAYER_WEIGHT_LOAD_EN
  logic signed [7:0] w_q [N_OUT][8];
  logic signed [7:0] b_q [N_OUT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        b_q[k] <= B_DEF[k];
        for (int i = 0; i < 8; i++)
          w_q[k][i] <= W_DEF[k][i];
      end
    end else if (wl_en && state_q == S_IDLE) begin
      if (wl_addr < 6'd32)
        w_q[wl_addr[4:3]][wl_addr[2:0]] <= wl_data;
      else if (wl_addr < 6'd36)
        b_q[wl_addr[1:0]] <= wl_data;
    end
  end

  assign bias_sel = b_q[k_d];
  assign term_sel = w_q[k_q][bit_q];
`else
  assign bias_sel = B_DEF[k_d];
  assign term_sel = W_DEF[k_q][bit_q];
`endif

  output_mac #(.ACC_W(ACC_W)) u_mac (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_i       (init),
    .add_i        (add),
    .cmp_i        (cmp),
    .first_i      (k_q == 2'd0),
    .bit_i        (hid_q[bit_q]),
    .idx_i        (k_q),
    .bias_i       (bias_sel),
    .term_i       (term_sel),
    .best_score_o (score_out),
    .best_idx_o   (cls_out)
  );

  assign hid_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_tt_um_output_layer.sv
// Directed-vector bench for tt_um_output_layer.
// Weight-load vectors run when OUTPUT_LAYER_WEIGHT_LOAD_EN is defined.
module tb_tt_um_output_layer;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        hid_in = 8'h00;
  logic              hid_valid = 1'b0;
  logic              hid_ready;
  logic [1:0]        cls_out;
  logic signed [11:0] score_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
`ifdef OUTPUT_LAYER_WEIGHT_LOAD_EN
  logic              wl_en = 1'b0;
  logic [5:0]        wl_addr = 6'd0;
  logic signed [7:0] wl_data = 8'sd0;
`endif

  tt_um_output_layer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hid_in    (hid_in),
    .hid_valid (hid_valid),
    .hid_ready (hid_ready),
    .cls_out   (cls_out),
    .score_out (score_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef OUTPUT_LAYER_WEIGHT_LOAD_EN
    ,
    .wl_en     (wl_en),
    .wl_addr   (wl_addr),
    .wl_data   (wl_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] h;
    int         cls;
    int         score;
  } vec_t;

  vec_t v [11];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Send one vector, scramble hid_in while busy, stall, then consume.
  task automatic run(input logic [7:0] h, input int stall,
                     output int c, output int s);
    int lat = 0;
    bit stable = 1'b1;
    @(negedge clk);
    chk("ready_idle", int'(hid_ready), 1);
    hid_in = h;
    hid_valid = 1'b1;
    @(posedge clk);
    #1;
    hid_in = ~h;
    chk("ready_busy", int'(hid_ready), 0);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 36);
    hid_valid = 1'b0;
    c = int'(cls_out);
    s = int'(score_out);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      if (int'(cls_out) != c || int'(score_out) != s ||
          out_valid !== 1'b1 || hid_ready !== 1'b0)
        stable = 1'b0;
    end
    if (stall > 0)
      chk("stall_stable", int'(stable), 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ready_after", int'(hid_ready), 1);
    chk("valid_after", int'(out_valid), 0);
  endtask

  initial begin
    int c, s;
    bit seen;

    v[0]  = '{8'b0000_0011, 0, 32};
    v[1]  = '{8'b1100_0000, 3, 32};
    v[2]  = '{8'hFF,        0, 8};
    v[3]  = '{8'b0011_0000, 2, 32};
    v[4]  = '{8'b0000_1100, 1, 32};
    v[5]  = '{8'h00,        0, 0};
    v[6]  = '{8'h01,        0, 16};
    v[7]  = '{8'h80,        3, 16};
    v[8]  = '{8'h05,        0, 12};
    v[9]  = '{8'h3C,        1, 24};
    v[10] = '{8'hF0,        2, 24};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", int'(hid_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_cls", int'(cls_out), 0);
    chk("rst_score", int'(score_out), 0);

    for (int i = 0; i < 11; i++) begin
      run(v[i].h, 0, c, s);
      chk($sformatf("cls[%0d]", i), c, v[i].cls);
      chk($sformatf("score[%0d]", i), s, v[i].score);
    end

    run(8'b1100_0000, 10, c, s);
    chk("stall_cls", c, 3);
    chk("stall_score", s, 32);

    // Abort in the middle of accumulation.
    @(negedge clk);
    hid_in = 8'b0000_0011;
    hid_valid = 1'b1;
    @(posedge clk);
    #1;
    hid_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", int'(hid_ready), 1);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_cls", int'(cls_out), 0);
    chk("abort_score", int'(score_out), 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", int'(seen), 0);
    run(8'b0011_0000, 0, c, s);
    chk("post_abort_cls", c, 2);
    chk("post_abort_score", s, 32);

`ifdef OUTPUT_LAYER_WEIGHT_LOAD_EN
    @(negedge clk);
    wl_en = 1'b1;
    wl_addr = 6'd32;
    wl_data = -8'sd100;
    @(posedge clk);
    #1;
    wl_en = 1'b0;
    run(8'b0000_0011, 0, c, s);
    chk("wl_cls", c, 1);
    chk("wl_score", s, -8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
